// File: rtl/fi_pkg.sv
// Shared types for the fault-injection scheduler:
// fault kinds, FSM states and the LFSR step.
package fi_pkg;

  typedef enum logic [1:0] {
    FT_NONE   = 2'd0,
    FT_FLIP   = 2'd1,
    FT_STUCK0 = 2'd2,
    FT_STUCK1 = 2'd3
  } ftype_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_INJECT,
    ST_FINISH
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] v
  );
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/fi_lfsr16.sv
// 16-bit Galois LFSR used to pick random one-hot
// fault bits; steps only when advance is high.
module fi_lfsr16
  import fi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] r_value;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_value <= LFSR_SEED;
    else if (advance)
      r_value <= lfsr_next(r_value);
  end

  assign value = r_value;

endmodule

// File: rtl/fault_inject_sched.sv
// Fault-injection campaign scheduler driving the
// register-file fault port: delay, hold, repeat.
module fault_inject_sched
  import fi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ADDRW-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [1:0]       cfg_type,
  input  logic             cfg_rand,
  input  logic [15:0]      cfg_delay,
  input  logic [15:0]      cfg_duration,
  input  logic [7:0]       cfg_repeat,
  output logic             fault_enable,
  output logic [ADDRW-1:0] fault_addr,
  output logic [WIDTH-1:0] fault_mask,
  output logic [1:0]       fault_type,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       inj_count
);

  state_e           r_state;
  state_e           w_next;
  logic [ADDRW-1:0] r_addr;
  ftype_e           r_type;
  logic [WIDTH-1:0] r_cfg_mask;
  logic [WIDTH-1:0] r_mask;
  logic             r_rand;
  logic             r_err;
  logic [15:0]      r_delay;
  logic [15:0]      r_dur;
  logic [15:0]      r_cnt;
  logic [7:0]       r_rep;
  logic [7:0]       r_inj;

  logic             w_idle;
  logic             w_accept;
  logic             w_reject;
  logic             w_enter_inj;
  logic             w_enter_wait;
  logic [15:0]      w_delay;
  logic [15:0]      w_dur;
  logic             w_rand;
  logic [WIDTH-1:0] w_fmask;
  logic [WIDTH-1:0] w_onehot;
  logic [15:0]      w_lfsr;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && start && !abort;
  assign w_reject = (cfg_type == FT_NONE) ||
                    (cfg_repeat == '0) ||
                    (cfg_duration == '0);

  // In the accept cycle the live cfg_* inputs apply
  assign w_delay = w_idle ? cfg_delay    : r_delay;
  assign w_dur   = w_idle ? cfg_duration : r_dur;
  assign w_rand  = w_idle ? cfg_rand     : r_rand;
  assign w_fmask = w_idle ? cfg_mask     : r_cfg_mask;

  assign w_onehot = WIDTH'(1) <<
                    (w_lfsr % 16'(WIDTH));

  fi_lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (w_enter_inj && w_rand),
    .value   (w_lfsr)
  );

  always_comb begin
    w_next       = r_state;
    w_enter_inj  = 1'b0;
    w_enter_wait = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_reject) begin
            w_next = ST_FINISH;
          end else if (cfg_delay == '0) begin
            w_next      = ST_INJECT;
            w_enter_inj = 1'b1;
          end else begin
            w_next       = ST_WAIT;
            w_enter_wait = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next      = ST_INJECT;
          w_enter_inj = 1'b1;
        end
      end
      ST_INJECT: begin
        if (r_cnt == '0) begin
          if (r_inj < r_rep) begin
            // zero delay chains injections back to back
            if (r_delay == '0) begin
              w_enter_inj = 1'b1;
            end else begin
              w_next       = ST_WAIT;
              w_enter_wait = 1'b1;
            end
          end else begin
            w_next = ST_FINISH;
          end
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (abort) begin
      w_next       = ST_IDLE;
      w_enter_inj  = 1'b0;
      w_enter_wait = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_type     <= FT_NONE;
      r_cfg_mask <= '0;
      r_mask     <= '0;
      r_rand     <= 1'b0;
      r_err      <= 1'b0;
      r_delay    <= '0;
      r_dur      <= '0;
      r_cnt      <= '0;
      r_rep      <= '0;
      r_inj      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr     <= cfg_addr;
        r_type     <= ftype_e'(cfg_type);
        r_cfg_mask <= cfg_mask;
        r_rand     <= cfg_rand;
        r_delay    <= cfg_delay;
        r_dur      <= cfg_duration;
        r_rep      <= cfg_repeat;
        r_err      <= w_reject;
      end
      if (w_enter_wait)
        r_cnt <= w_delay - 16'd1;
      else if (w_enter_inj)
        r_cnt <= w_dur - 16'd1;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 16'd1;
      if (w_enter_inj)
        r_inj <= (w_accept ? 8'd0 : r_inj) + 8'd1;
      else if (w_accept)
        r_inj <= '0;
      if (w_enter_inj)
        r_mask <= w_rand ? w_onehot : w_fmask;
    end
  end

  assign fault_enable = (r_state == ST_INJECT);
  assign fault_mask   = fault_enable ? r_mask : '0;
  assign fault_addr   = r_addr;
  assign fault_type   = r_type;
  assign busy         = (r_state == ST_WAIT) ||
                        (r_state == ST_INJECT);
  assign done         = (r_state == ST_FINISH);
  assign err          = done && r_err;
  assign inj_count    = r_inj;

endmodule

// File: tb/tb_fault_inject_sched.sv
// Bench for fault_inject_sched: schedule-level model
// checked every cycle plus hand-computed vectors.
module tb_fault_inject_sched;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_mask = '0;
  logic [1:0]    cfg_type = '0;
  logic          cfg_rand = 1'b0;
  logic [15:0]   cfg_delay = '0;
  logic [15:0]   cfg_duration = '0;
  logic [7:0]    cfg_repeat = '0;
  logic          fault_enable;
  logic [AW-1:0] fault_addr;
  logic [W-1:0]  fault_mask;
  logic [1:0]    fault_type;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    inj_count;

  always #5 clk = ~clk;

  fault_inject_sched #(
    .WIDTH(W), .DEPTH(D), .ADDRW(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_addr     (cfg_addr),
    .cfg_mask     (cfg_mask),
    .cfg_type     (cfg_type),
    .cfg_rand     (cfg_rand),
    .cfg_delay    (cfg_delay),
    .cfg_duration (cfg_duration),
    .cfg_repeat   (cfg_repeat),
    .fault_enable (fault_enable),
    .fault_addr   (fault_addr),
    .fault_mask   (fault_mask),
    .fault_type   (fault_type),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .inj_count    (inj_count)
  );

  // register file with fault port; x7 holds zero
  localparam logic [AW-1:0] RD_A = 5'd7;
  logic [W-1:0] rf_x7 = '0;
  logic [W-1:0] rdata;
  always_comb begin
    rdata = rf_x7;
    if (fault_enable && fault_addr == RD_A) begin
      case (fault_type)
        2'd1:    rdata = rf_x7 ^ fault_mask;
        2'd2:    rdata = rf_x7 & ~fault_mask;
        2'd3:    rdata = rf_x7 | fault_mask;
        default: rdata = rf_x7;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h cyc %0d",
                  nm, act, exp, cyc);
  endtask

  // ---- schedule model ----
  bit            m_valid = 1'b0;
  int            m_T = 0;
  int            m_abort = BIG;
  int            m_d, m_u, m_rep;
  bit            m_err, m_rand;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] p_addr = '0;
  logic [1:0]    m_type = '0;
  logic [1:0]    p_type = '0;
  int            p_cnt = 0;
  logic [15:0]   m_lfsr = 16'hACE1;
  logic [W-1:0]  m_masks [256];

  typedef struct {
    logic          en;
    logic [W-1:0]  mask;
    logic [AW-1:0] addr;
    logic [1:0]    typ;
    logic          busy, done, err;
    logic [7:0]    cnt;
  } exp_t;

  function automatic logic [15:0] ref_step(
    input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int started(input int c);
    int cc, r, per, n;
    if (!m_valid || m_err) return 0;
    cc = (c < m_abort) ? c : m_abort;
    if (cc <= m_T) return 0;
    r = cc - m_T - 1;
    per = m_d + m_u;
    n = r / per;
    if (r % per >= m_d) n++;
    if (n > m_rep) n = m_rep;
    return n;
  endfunction

  function automatic int end_cyc();
    if (m_err) return m_T + 1;
    return m_T + 1 + m_rep * (m_d + m_u);
  endfunction

  function automatic bit m_idle(input int c);
    return !m_valid || c <= m_T ||
           c > end_cyc() || c > m_abort;
  endfunction

  task automatic m_accept(
    input logic [AW-1:0] a, input logic [W-1:0] m,
    input logic [1:0] t, input logic rnd,
    input int dl, input int du, input int rp);
    logic [15:0] v;
    if (m_valid) begin
      p_cnt  = started(BIG);
      p_addr = m_addr;
      p_type = m_type;
      if (m_rand)
        for (int k = 0; k < p_cnt; k++)
          m_lfsr = ref_step(m_lfsr);
    end else begin
      p_cnt = 0; p_addr = '0; p_type = '0;
    end
    m_valid = 1'b1;
    m_T = cyc;
    m_abort = BIG;
    m_addr = a; m_type = t; m_rand = rnd;
    m_d = dl; m_u = du; m_rep = rp;
    m_err = (t == 2'd0) || (rp == 0) || (du == 0);
    v = m_lfsr;
    for (int k = 0; k < rp; k++) begin
      m_masks[k] = rnd ? (W'(1) << (v % W)) : m;
      if (rnd) v = ref_step(v);
    end
  endtask

  function automatic exp_t model_at(input int c);
    exp_t e;
    int r, per, k, off;
    e.en = 0; e.mask = '0; e.addr = '0; e.typ = '0;
    e.busy = 0; e.done = 0; e.err = 0; e.cnt = '0;
    if (!m_valid) return e;
    if (c <= m_T) begin
      e.addr = p_addr; e.typ = p_type;
      e.cnt = 8'(p_cnt);
      return e;
    end
    e.addr = m_addr; e.typ = m_type;
    e.cnt = 8'(started(c));
    if (c > m_abort) return e;
    if (m_err) begin
      e.done = (c == m_T + 1);
      e.err = e.done;
      return e;
    end
    r = c - m_T - 1;
    per = m_d + m_u;
    k = r / per;
    off = r % per;
    if (k < m_rep) begin
      e.busy = 1;
      if (off >= m_d) begin
        e.en = 1;
        e.mask = m_masks[k];
      end
    end else if (r == m_rep * per) begin
      e.done = 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (chk_on) begin
      e = model_at(cyc);
      chk("fault_enable", fault_enable, e.en);
      chk("fault_mask", fault_mask, e.mask);
      chk("fault_addr", fault_addr, e.addr);
      chk("fault_type", fault_type, e.typ);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("err", err, e.err);
      chk("inj_count", inj_count, e.cnt);
    end
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(
    input logic [AW-1:0] a, input logic [W-1:0] m,
    input logic [1:0] t, input logic rnd,
    input int dl, input int du, input int rp,
    input logic ab);
    cfg_addr = a; cfg_mask = m; cfg_type = t;
    cfg_rand = rnd; cfg_delay = 16'(dl);
    cfg_duration = 16'(du); cfg_repeat = 8'(rp);
    start = 1'b1;
    abort = ab;
    if (ab && m_valid && cyc < m_abort) m_abort = cyc;
    if (!ab && m_idle(cyc))
      m_accept(a, m, t, rnd, dl, du, rp);
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    if (m_valid && cyc < m_abort) m_abort = cyc;
    tick();
    abort = 1'b0;
  endtask

  logic [12:0] enh, dnh, erh;
  logic [W-1:0] rm [4];
  logic [W-1:0] rdh [6];
  int nm;
  logic prev_en, dacc;

  initial begin
    rst_n = 1'b0;
    tick();
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", inj_count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // fixed campaign, delay 2, duration 3, repeat 2
    go(5, 32'h1, 1, 0, 2, 3, 2, 0);
    enh = '0; dnh = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      enh[i] = fault_enable;
      dnh[i] = done;
      tick();
    end
    chk("fix_en_pattern", enh, 13'h0738);
    chk("fix_done_pattern", dnh, 13'h0800);
    @(negedge clk);
    chk("fix_count", inj_count, 2);
    tick();

    // rejected configs
    go(2, 32'hFFFF_FFFF, 0, 0, 1, 3, 2, 0);
    enh = '0; dnh = '0; erh = '0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      enh[i] = fault_enable;
      dnh[i] = done;
      erh[i] = err;
      tick();
    end
    chk("rej_en", enh, 13'h0);
    chk("rej_done", dnh, 13'h2);
    chk("rej_err", erh, 13'h2);
    go(3, 32'h1, 1, 0, 0, 3, 0, 0);
    repeat (2) tick();
    go(3, 32'h1, 1, 0, 0, 0, 2, 0);
    @(negedge clk);
    chk("rej_dur0", {done, err}, 2'b11);
    repeat (2) tick();

    // abort during INJECT
    go(9, 32'hF0, 2, 0, 1, 5, 3, 0);
    tick();
    tick();
    pulse_abort();
    dacc = 1'b0;
    @(negedge clk);
    chk("abort_en", fault_enable, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", inj_count, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dacc = dacc | done;
      tick();
    end
    chk("abort_no_done", dacc, 0);

    // random one-hot masks
    go(4, 32'h0, 1, 1, 1, 2, 4, 0);
    nm = 0;
    prev_en = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (fault_enable && !prev_en && nm < 4) begin
        rm[nm] = fault_mask;
        nm++;
      end
      prev_en = fault_enable;
      tick();
    end
    chk("rand_n", nm, 4);
    chk("rand_m0", rm[0], 32'h0000_0002);
    chk("rand_m1", rm[1], 32'h0001_0000);
    chk("rand_m2", rm[2], 32'h0100_0000);
    chk("rand_m3", rm[3], 32'h1000_0000);
    for (int i = 0; i < 4; i++)
      chk("rand_onehot", $onehot(rm[i]), 1);

    // start and abort together in IDLE
    go(1, 32'h1, 1, 0, 0, 2, 1, 1);
    @(negedge clk);
    chk("sa_busy", busy, 0);
    chk("sa_en", fault_enable, 0);
    tick();

    // start while busy is ignored
    go(3, 32'hA, 2, 0, 0, 4, 1, 0);
    @(negedge clk);
    chk("d0_en", fault_enable, 1);
    tick();
    go(12, 32'h5, 3, 0, 0, 2, 1, 0);
    @(negedge clk);
    chk("busy_addr", fault_addr, 3);
    chk("busy_type", fault_type, 2);
    repeat (5) tick();

    // stuck-1 on x7 seen through the regfile
    go(7, 32'hFF, 3, 0, 1, 2, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      rdh[i] = rdata;
      tick();
    end
    chk("rf_c1", rdh[1], 32'h0);
    chk("rf_c2", rdh[2], 32'hFF);
    chk("rf_c3", rdh[3], 32'hFF);
    chk("rf_c4", rdh[4], 32'h0);
    chk("rf_c5", rdh[5], 32'h0);

    // reset mid-campaign, then LFSR must restart
    go(6, 32'h3, 1, 0, 1, 4, 3, 0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    m_valid = 1'b0;
    m_abort = BIG;
    m_lfsr = 16'hACE1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_en", fault_enable, 0);
    chk("rst_mid_cnt", inj_count, 0);
    chk("rst_mid_addr", fault_addr, 0);
    tick();
    go(8, 32'h0, 1, 1, 0, 1, 1, 0);
    @(negedge clk);
    chk("rst_lfsr_mask", fault_mask, 32'h2);
    repeat (3) tick();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fault_inject_sched.md
FAULT_INJECT_SCHED -- requirements
Module: fault_inject_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width.
REQ-002 SHALL have parameter DEPTH, default 32, register count.
REQ-003 SHALL have parameter ADDRW, default $clog2(DEPTH), register address width.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle campaign request.
REQ-007 SHALL have port abort  in  1  terminate campaign.
REQ-008 SHALL have port cfg_addr  in  ADDRW  target register.
REQ-009 SHALL have port cfg_mask  in  WIDTH  fault mask for fixed mode.
REQ-010 SHALL have port cfg_type  in  2  0=none, 1=flip, 2=stuck-0, 3=stuck-1.
REQ-011 SHALL have port cfg_rand  in  1  1 = one-hot mask from LFSR per injection.
REQ-012 SHALL have port cfg_delay  in  16  idle cycles before each injection.
REQ-013 SHALL have port cfg_duration  in  16  cycles each injection is held.
REQ-014 SHALL have port cfg_repeat  in  8  number of injections.
REQ-015 SHALL have port fault_enable  out  1  to register-file fault port.
REQ-016 SHALL have port fault_addr  out  ADDRW  to register-file fault port.
REQ-017 SHALL have port fault_mask  out  WIDTH  to register-file fault port.
REQ-018 SHALL have port fault_type  out  2  to register-file fault port.
REQ-019 SHALL have port busy  out  1  campaign in progress.
REQ-020 SHALL have port done  out  1  one-cycle completion pulse.
REQ-021 SHALL have port err  out  1  qualifies done: config rejected.
REQ-022 SHALL have port inj_count  out  8  injections started this campaign.

Function
REQ-023 SHALL implement FSM states IDLE, WAIT, INJECT, FINISH.
REQ-024 SHALL accept start only in IDLE, latching all cfg_* in the accept cycle T; start elsewhere ignored.
REQ-025 SHALL reject start when cfg_type==0, cfg_repeat==0 or cfg_duration==0: FINISH at T+1, done=err=1 at T+1, no injection.
REQ-026 SHALL count cfg_delay cycles in WAIT; delay 0 enters INJECT so fault_enable=1 at T+1.
REQ-027 SHALL hold fault_enable=1 for exactly cfg_duration consecutive cycles per injection.
REQ-028 SHALL increment inj_count on entering INJECT; saturate never needed (bounded by cfg_repeat).
REQ-029 SHALL, after INJECT, return to WAIT if inj_count<cfg_repeat, else enter FINISH.
REQ-030 SHALL pulse done (err=0) for one cycle in FINISH, then IDLE; busy=1 in WAIT/INJECT.
REQ-031 SHALL drive fault_addr/fault_type from latched config and fault_mask=0 whenever fault_enable=0.
REQ-032 SHALL in cfg_rand mode use mask = 1<<(lfsr mod WIDTH), LFSR advancing once per INJECT entry.
REQ-033 SHALL use 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
REQ-034 SHALL on abort in any state go to IDLE next cycle, fault_enable=0 next cycle, no done pulse.
REQ-035 SHALL give abort priority over simultaneous start.
REQ-036 SHALL permit cfg_addr==0 (register file ignores it); no special handling.
REQ-037 SHALL keep inj_count until next accepted start, which clears it.

Reset
REQ-038 SHALL on rst_n=0 set state IDLE, all outputs 0, inj_count 0, LFSR to seed.
REQ-039 SHALL treat reset mid-campaign as abort: fault_enable=0 the cycle after rst_n sampled low.

Structure
REQ-040 SHALL place fault-type enum (FT_NONE/FT_FLIP/FT_STUCK0/FT_STUCK1) and FSM state enum in package fi_pkg.
REQ-041 SHALL implement the LFSR as sub-module fi_lfsr16 (clk, rst_n, advance, value).

Verification
REQ-042 SHALL test fixed: addr=5, mask=32'h1, type=1, delay=2, duration=3, repeat=2 -> enable high T+3..T+5 and T+8..T+10, done at T+11, inj_count=2.
REQ-043 SHALL test reject: type=0 -> done=err=1 at T+1, fault_enable never high.
REQ-044 SHALL test abort during INJECT -> fault_enable=0 next cycle, busy=0, no done.
REQ-045 SHALL test cfg_rand, repeat=4 -> each mask one-hot, matching reference LFSR model from 16'hACE1.
REQ-046 SHALL test start+abort same cycle in IDLE -> stays IDLE; start during busy -> ignored.
REQ-047 SHALL test with regfile attached: type=3 mask=32'hFF on x7 holding 0 -> rdata reads 32'hFF only while enabled.
